pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline around the instruction decoder: detects load-use hazards,
//  squashes wrong-path instructions on taken branches/jumps, and runs the multi-cycle
//  mult/div handshake, freezing F/D and D/X while the multdiv unit is busy.
//  Sits beside the D/X and X/M latches; drives their hold/nop controls and the multdiv start pulses.
// PARAMETERS
//  MD_TIMEOUT  40  max BUSY cycles without md_ready before forced completion
//  CNT_W        6  width of busy counter; must satisfy 2**CNT_W > MD_TIMEOUT
// PORTS
//  clock         in   1   rising-edge clock
//  reset         in   1   asynchronous, active-high
//  d_insn        in  32   instruction in F/D latch (decode stage)
//  x_insn        in  32   instruction in D/X latch (execute stage)
//  x_valid       in   1   D/X holds a real (non-nop) instruction
//  branch_taken  in   1   X stage resolved a taken bne/blt/bex or j/jal/jr
//  md_ready      in   1   multdiv result valid; held by the unit until next start
//  hold_fd       out  1   freeze PC and F/D latch
//  hold_dx       out  1   freeze D/X latch
//  nop_dx        out  1   load nop into D/X next edge
//  nop_xm        out  1   load nop into X/M next edge
//  flush_fd      out  1   load nop into F/D next edge
//  md_mult       out  1   one-cycle mult start pulse
//  md_div        out  1   one-cycle div start pulse
//  md_busy       out  1   FSM in BUSY
//  md_timeout    out  1   one-cycle pulse: BUSY ended by timeout
//  state         out  2   FSM state (debug)
// BEHAVIOUR
//  - Fields: opcode=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], ALUOp=[6:2]. mult: opcode 00000, ALUOp 00110; div: ALUOp 00111.
//  - Reset (async): state=IDLE, counter=0; all outputs 0 while reset high and in the first IDLE cycle absent hazards.
//  - FSM IDLE(00) / BUSY(01) / DONE(10); 11 unreachable -> next IDLE.
//  - IDLE, x_valid & X is mult/div: md_mult|md_div=1 (combinational, this cycle only), hold_fd=hold_dx=nop_xm=1, next BUSY, counter<=0.
//  - BUSY: hold_fd=hold_dx=nop_xm=1, md_busy=1; counter++ each cycle. md_ready -> DONE.
//    Else counter==MD_TIMEOUT-1 -> md_timeout=1 that cycle, next DONE. md_ready wins if both.
//  - DONE: all holds/nops 0 for exactly one cycle so the result enters X/M; next IDLE. New X instruction evaluated fresh in IDLE.
//  - Load-use (IDLE, no multdiv in X): X opcode 01000, x_valid, X.rd!=0, and D reads X.rd
//    -> hold_fd=1, nop_dx=1 (one cycle; combinational). D sources: R-type rs,rt; addi/lw rs; sw rs,rd; bne/blt rd,rs; jr rd; bex r30.
//  - branch_taken (IDLE): flush_fd=1, nop_dx=1, hold_fd=0; overrides load-use (D is wrong-path).
//  - branch_taken ignored outside IDLE (X holds multdiv, cannot be a branch).
//  - r0 never causes a hazard. x_valid=0 suppresses every X-based detection.
//  - Reset mid-BUSY: immediate IDLE, pulses dropped; multdiv unit restarts on next start pulse.
// STRUCTURE
//  - Package proc_ctrl_pkg: opcode constants (ALU 00000, ADDI 00101, J 00001, JAL 00011, JR 00100,
//    BNE 00010, BLT 00110, BEX 10110, SETX 10101, LW 01000, SW 00111), ALUOp MULT/DIV, state encodings.
//  - Sub-module hazard_src_decode: combinational; d_insn -> {src1, src2, src1_v, src2_v}. FSM and counter stay in top.
// TESTING
//  - Reset mid-BUSY: div in X, 5 BUSY cycles, pulse reset -> state=00, all outputs 0 same cycle.
//  - mult r3,r1,r2 in X, md_ready at BUSY cycle 17 -> md_mult 1 cycle, holds 1 for 18 cycles, DONE 1 cycle, state 00->01->10->00.
//  - lw r5 in X, D=add r6,r5,r7 -> hold_fd=1, nop_dx=1 one cycle; D=add r6,r0,r7 with lw r0 -> no stall.
//  - lw r5 in X, D=bne r5,r2 and branch_taken=1 -> flush_fd=1, nop_dx=1, hold_fd=0.
//  - div in X, md_ready never -> md_timeout pulse on BUSY cycle 40 (MD_TIMEOUT=40), then DONE, IDLE.
//  - x_valid=0 with mult encoding in X -> no start pulse, state stays 00.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// proc_ctrl_pkg
//   Shared constants and types for the pipeline hazard controller: instruction
//   opcodes, ALUOp codes for the multdiv unit, the multdiv FSM encoding, the
//   decoded-source bundle and the hold/nop/start control bundle.
// -----------------------------------------------------------------------------
package proc_ctrl_pkg;

    // Primary opcodes, insn[31:27]
    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    // ALUOp field, insn[6:2], for R-type multdiv
    localparam logic [4:0] ALUOP_MULT = 5'b00110;
    localparam logic [4:0] ALUOP_DIV  = 5'b00111;

    // bex implicitly tests the status register
    localparam logic [4:0] REG_STATUS = 5'd30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // Register sources read by the decode-stage instruction
    typedef struct packed {
        logic [4:0] src1;
        logic [4:0] src2;
        logic       src1_v;
        logic       src2_v;
    } hazard_src_t;

    // Pipeline control outputs, bundled so they can be cleared in one place
    typedef struct packed {
        logic hold_fd;
        logic hold_dx;
        logic nop_dx;
        logic nop_xm;
        logic flush_fd;
        logic md_mult;
        logic md_div;
        logic md_busy;
        logic md_timeout;
    } ctrl_t;

endpackage : proc_ctrl_pkg

// File: rtl/hazard_src_decode.sv
// -----------------------------------------------------------------------------
// hazard_src_decode
//   Combinational decode of the F/D instruction into the set of registers it
//   reads, used for load-use detection.
// Ports
//   insn_i  in  32  instruction in the F/D latch
//   src_o   out     {src1, src2, src1_v, src2_v}
// -----------------------------------------------------------------------------
module hazard_src_decode
    import proc_ctrl_pkg::*;
(
    input  logic [31:0] insn_i,
    output hazard_src_t src_o
);

    logic [4:0] op;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;

    assign op = insn_i[31:27];
    assign rd = insn_i[26:22];
    assign rs = insn_i[21:17];
    assign rt = insn_i[16:12];

    // Immediate / shamt / ALUOp bits carry no register sources
    logic unused_low_bits;
    assign unused_low_bits = ^insn_i[11:0];

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        src_o = '0;
        unique case (op)
            OP_ALU: begin
                src_o.src1   = rs;
                src_o.src1_v = 1'b1;
                src_o.src2   = rt;
                src_o.src2_v = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                src_o.src1   = rs;
                src_o.src1_v = 1'b1;
            end
            // sw stores rd; bne/blt compare rd against rs
            OP_SW, OP_BNE, OP_BLT: begin
                src_o.src1   = rs;
                src_o.src1_v = 1'b1;
                src_o.src2   = rd;
                src_o.src2_v = 1'b1;
            end
            OP_JR: begin
                src_o.src1   = rd;
                src_o.src1_v = 1'b1;
            end
            OP_BEX: begin
                src_o.src1   = REG_STATUS;
                src_o.src1_v = 1'b1;
            end
            default: ;  // j, jal, setx and unknown opcodes read nothing
        endcase
    end

endmodule : hazard_src_decode

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard and multdiv sequencing for the 5-stage pipeline: load-use stalls,
//   wrong-path squash on taken branches/jumps, and the multi-cycle mult/div
//   handshake that freezes F/D and D/X while the unit is busy.
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   d_insn, x_insn, x_valid      decode / execute instructions, X validity
//   branch_taken, md_ready       X-stage redirect, multdiv result valid
//   hold_fd, hold_dx             freeze PC+F/D, freeze D/X
//   nop_dx, nop_xm, flush_fd     insert nop into D/X, X/M, F/D next edge
//   md_mult, md_div              one-cycle multdiv start pulses
//   md_busy, md_timeout          FSM in BUSY, BUSY ended by timeout
//   state                        FSM state (debug)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] d_insn,
    input  logic [31:0] x_insn,
    input  logic        x_valid,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        hold_fd,
    output logic        hold_dx,
    output logic        nop_dx,
    output logic        nop_xm,
    output logic        flush_fd,
    output logic        md_mult,
    output logic        md_div,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [1:0]  state
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl;

    // Execute-stage fields
    logic [4:0] x_op;
    logic [4:0] x_rd;
    logic [4:0] x_aluop;
    assign x_op    = x_insn[31:27];
    assign x_rd    = x_insn[26:22];
    assign x_aluop = x_insn[6:2];

    logic unused_x_bits;
    assign unused_x_bits = ^{x_insn[21:7], x_insn[1:0]};

    logic x_mult;
    logic x_div;
    assign x_mult = x_valid && (x_op == OP_ALU) && (x_aluop == ALUOP_MULT);
    assign x_div  = x_valid && (x_op == OP_ALU) && (x_aluop == ALUOP_DIV);

    hazard_src_t d_src;

    hazard_src_decode u_src_decode (
        .insn_i (d_insn),
        .src_o  (d_src)
    );

    // r0 is hard-wired zero, so a load into it never produces a dependency
    logic load_use;
    assign load_use = x_valid && (x_op == OP_LW) && (x_rd != 5'd0) &&
                      ((d_src.src1_v && (d_src.src1 == x_rd)) ||
                       (d_src.src2_v && (d_src.src2 == x_rd)));

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (x_mult || x_div) begin
                    ctrl.md_mult = x_mult;
                    ctrl.md_div  = x_div;
                    ctrl.hold_fd = 1'b1;
                    ctrl.hold_dx = 1'b1;
                    ctrl.nop_xm  = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_BUSY;
                end else if (branch_taken) begin
                    // D holds a wrong-path instruction: squash it rather than stall
                    ctrl.flush_fd = 1'b1;
                    ctrl.nop_dx   = 1'b1;
                end else if (load_use) begin
                    ctrl.hold_fd = 1'b1;
                    ctrl.nop_dx  = 1'b1;
                end
            end
            ST_BUSY: begin
                ctrl.hold_fd = 1'b1;
                ctrl.hold_dx = 1'b1;
                ctrl.nop_xm  = 1'b1;
                ctrl.md_busy = 1'b1;
                cnt_d        = cnt_q + CNT_W'(1);
                if (md_ready) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
                    ctrl.md_timeout = 1'b1;
                    state_d         = ST_DONE;
                end
            end
            ST_DONE: begin
                // One open cycle lets the multdiv result advance into X/M
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controls are combinational; force them quiet while reset is asserted
    ctrl_t ctrl_out;
    assign ctrl_out = reset ? '0 : ctrl;

    assign hold_fd    = ctrl_out.hold_fd;
    assign hold_dx    = ctrl_out.hold_dx;
    assign nop_dx     = ctrl_out.nop_dx;
    assign nop_xm     = ctrl_out.nop_xm;
    assign flush_fd   = ctrl_out.flush_fd;
    assign md_mult    = ctrl_out.md_mult;
    assign md_div     = ctrl_out.md_div;
    assign md_busy    = ctrl_out.md_busy;
    assign md_timeout = ctrl_out.md_timeout;
    assign state      = state_q;

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed and randomized checks of pipeline_hazard_ctrl against a
//   behavioural model of the hazard and multdiv rules.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int TO = 40;

    // Instruction encodings
    localparam logic [4:0] T_ALU = 5'b00000, T_J = 5'b00001, T_BNE = 5'b00010,
                           T_JAL = 5'b00011, T_JR = 5'b00100, T_ADDI = 5'b00101,
                           T_BLT = 5'b00110, T_SW = 5'b00111, T_LW = 5'b01000,
                           T_SETX = 5'b10101, T_BEX = 5'b10110;
    localparam logic [4:0] T_MULT = 5'b00110, T_DIV = 5'b00111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] d_insn = '0;
    logic [31:0] x_insn = '0;
    logic        x_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        hold_fd, hold_dx, nop_dx, nop_xm, flush_fd;
    logic        md_mult, md_div, md_busy, md_timeout;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int hold_seen = 0;
    int timeout_seen = 0;

    // Model: busy_age is the number of BUSY cycles already completed
    // (-1 when no multdiv is running); in_done marks the release cycle.
    int busy_age = -1;
    bit in_done  = 1'b0;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .d_insn(d_insn), .x_insn(x_insn),
        .x_valid(x_valid), .branch_taken(branch_taken), .md_ready(md_ready),
        .hold_fd(hold_fd), .hold_dx(hold_dx), .nop_dx(nop_dx), .nop_xm(nop_xm),
        .flush_fd(flush_fd), .md_mult(md_mult), .md_div(md_div),
        .md_busy(md_busy), .md_timeout(md_timeout), .state(state)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [31:0] r_insn(logic [4:0] op, logic [4:0] rd,
                                           logic [4:0] rs, logic [4:0] rt,
                                           logic [4:0] aluop);
        return {op, rd, rs, rt, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] i_insn(logic [4:0] op, logic [4:0] rd,
                                           logic [4:0] rs, logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Does instruction `insn` read register r?
    function automatic bit reads_reg(logic [31:0] insn, logic [4:0] r);
        logic [4:0] op, rd, rs, rt;
        op = insn[31:27]; rd = insn[26:22]; rs = insn[21:17]; rt = insn[16:12];
        case (op)
            T_ALU:               return (rs == r) || (rt == r);
            T_ADDI, T_LW:        return rs == r;
            T_SW, T_BNE, T_BLT:  return (rs == r) || (rd == r);
            T_JR:                return rd == r;
            T_BEX:               return r == 5'd30;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic bit x_is_md();
        return x_valid && x_insn[31:27] == T_ALU &&
               (x_insn[6:2] == T_MULT || x_insn[6:2] == T_DIV);
    endfunction

    // Expected {hold_fd,hold_dx,nop_dx,nop_xm,flush_fd,mult,div,busy,timeout,state}
    function automatic logic [10:0] model_expect();
        logic hf, hd, nd, nx, ff, mm, mdv, mb, mt;
        logic [1:0] st;
        {hf, hd, nd, nx, ff, mm, mdv, mb, mt} = '0;
        st = 2'd0;
        if (reset) begin
            st = 2'd0;
        end else if (in_done) begin
            st = 2'd2;
        end else if (busy_age >= 0) begin
            st = 2'd1;
            hf = 1; hd = 1; nx = 1; mb = 1;
            mt = !md_ready && (busy_age == TO - 1);
        end else if (x_is_md()) begin
            hf = 1; hd = 1; nx = 1;
            mm = (x_insn[6:2] == T_MULT);
            mdv = (x_insn[6:2] == T_DIV);
        end else if (branch_taken) begin
            ff = 1; nd = 1;
        end else if (x_valid && x_insn[31:27] == T_LW && x_insn[26:22] != 0 &&
                     reads_reg(d_insn, x_insn[26:22])) begin
            hf = 1; nd = 1;
        end
        return {hf, hd, nd, nx, ff, mm, mdv, mb, mt, st};
    endfunction

    function automatic void model_advance();
        if (reset) begin
            busy_age = -1; in_done = 1'b0;
        end else if (in_done) begin
            in_done = 1'b0;
        end else if (busy_age >= 0) begin
            if (md_ready || busy_age == TO - 1) begin
                busy_age = -1; in_done = 1'b1;
            end else begin
                busy_age++;
            end
        end else if (x_is_md()) begin
            busy_age = 0;
        end
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check this cycle's outputs, then advance one clock
    task automatic tick(string tag);
        logic [10:0] obs;
        #1;
        obs = {hold_fd, hold_dx, nop_dx, nop_xm, flush_fd, md_mult, md_div,
               md_busy, md_timeout, state};
        check(tag, 32'(obs), 32'(model_expect()));
        if (hold_fd)    hold_seen++;
        if (md_timeout) timeout_seen++;
        @(posedge clock);
        model_advance();
        #1;
    endtask

    function automatic logic [4:0] rand_reg();
        logic [4:0] r;
        r = 5'($urandom_range(0, 8));
        return (r == 5'd8) ? 5'd30 : r;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [4:0] ops [12];
        logic [4:0] op;
        ops = '{T_ALU, T_J, T_BNE, T_JAL, T_JR, T_ADDI, T_BLT, T_SW, T_LW,
                T_SETX, T_BEX, T_LW};
        op = ops[$urandom_range(0, 11)];
        if (op == T_ALU)
            return r_insn(op, rand_reg(), rand_reg(), rand_reg(),
                          5'($urandom_range(0, 7)));
        return i_insn(op, rand_reg(), rand_reg(), 17'($urandom));
    endfunction

    initial begin
        #1 reset = 1'b1;
        // Reset gates outputs even with a valid mult in X
        x_valid = 1; x_insn = r_insn(T_ALU, 3, 1, 2, T_MULT);
        tick("reset_mult_in_x");
        tick("reset_hold");
        reset = 0; x_valid = 0; x_insn = '0;
        tick("idle_after_reset");

        // mult r3,r1,r2 with md_ready on BUSY cycle 17
        x_valid = 1; x_insn = r_insn(T_ALU, 3, 1, 2, T_MULT);
        hold_seen = 0;
        tick("mult_start");
        for (int i = 1; i <= 17; i++) begin
            md_ready = (i == 17);
            tick("mult_busy");
        end
        tick("mult_done");
        check("mult_hold_cycles", 32'(hold_seen), 32'd18);
        x_insn = r_insn(T_ALU, 4, 3, 3, 5'd0);
        tick("mult_back_idle");
        md_ready = 0;

        // Load-use
        x_insn = i_insn(T_LW, 5, 1, 17'd0);
        d_insn = r_insn(T_ALU, 6, 5, 7, 5'd0);
        tick("lu_rs");
        d_insn = r_insn(T_ALU, 6, 7, 5, 5'd0);
        tick("lu_rt");
        d_insn = r_insn(T_ALU, 6, 7, 8, 5'd0);
        tick("lu_none");
        x_insn = i_insn(T_LW, 0, 1, 17'd0);
        d_insn = r_insn(T_ALU, 6, 0, 7, 5'd0);
        tick("lu_r0");
        x_valid = 0; x_insn = i_insn(T_LW, 5, 1, 17'd0);
        d_insn = r_insn(T_ALU, 6, 5, 7, 5'd0);
        tick("lu_xinvalid");
        x_valid = 1;
        d_insn = i_insn(T_BEX, 0, 0, 17'd9); x_insn = i_insn(T_LW, 30, 1, 17'd0);
        tick("lu_bex");
        d_insn = i_insn(T_SW, 5, 2, 17'd0); x_insn = i_insn(T_LW, 5, 1, 17'd0);
        tick("lu_sw_rd");

        // Branch overrides load-use
        d_insn = i_insn(T_BNE, 5, 2, 17'd4); branch_taken = 1;
        tick("branch_flush");
        branch_taken = 0;
        tick("branch_lu_only");

        // div timeout
        x_insn = r_insn(T_ALU, 9, 1, 2, T_DIV); timeout_seen = 0;
        tick("div_start");
        x_valid = 0;  // ignored while busy
        for (int i = 1; i <= TO; i++) tick("div_busy");
        tick("div_done");
        check("div_timeout_pulses", 32'(timeout_seen), 32'd1);
        tick("div_idle");

        // Reset mid-BUSY
        x_valid = 1;
        tick("div2_start");
        for (int i = 0; i < 5; i++) tick("div2_busy");
        reset = 1;
        tick("reset_mid_busy");
        reset = 0; x_valid = 0;
        tick("after_mid_reset");

        // x_valid=0 mult
        x_insn = r_insn(T_ALU, 3, 1, 2, T_MULT);
        tick("mult_invalid");
        tick("mult_invalid_stay");

        // Randomized
        for (int n = 0; n < 600; n++) begin
            x_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0: x_insn = r_insn(T_ALU, rand_reg(), rand_reg(), rand_reg(), T_MULT);
                1: x_insn = r_insn(T_ALU, rand_reg(), rand_reg(), rand_reg(), T_DIV);
                default: x_insn = rand_insn();
            endcase
            d_insn = rand_insn();
            branch_taken = x_is_md() ? 1'b0 : ($urandom_range(0, 4) == 0);
            md_ready = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick("random");
        end
        reset = 0;
        tick("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
